serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 157 +++++++++++++++
 tb/tb_serial_addsub.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// serial_addsub -- digit-serial two's-complement adder/subtractor.
//
// Processes DIGIT bits per clock, least-significant slice first, so an
// operation takes N = WIDTH/DIGIT cycles after the accepting edge. Result
// outputs only change on the cycle the last slice completes.
//
// Ports:
//   clk      : clock, all state changes on the rising edge
//   reset    : asynchronous, active-high reset
//   start    : operation request, sampled on a rising edge while idle
//   sub      : 0 = a + b, 1 = a - b (captured with start)
//   a, b     : WIDTH-bit signed operands (captured with start)
//   busy     : high while an operation is in progress
//   done     : one-cycle pulse when the result outputs were just updated
//   sum      : WIDTH-bit result, modulo 2^WIDTH
//   carryout : raw carry out of bit WIDTH-1 (no borrow inversion)
//   overflow : signed overflow (carry into MSB xor carry out of MSB)
//   zero     : high when sum is all zeros
//
// WIDTH must be >= 2 and an integer multiple of DIGIT.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;      // holds ~b for subtract
  logic [WIDTH-1:0] acc_q, acc_d;  // partial result, filled from the top
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;
  logic             zero_q, zero_d;
  logic [CW-1:0]    idx_q, idx_d;

  // Slice datapath: always works on the low DIGIT bits of the operand
  // shift registers, so no variable part-selects are needed.
  logic [DIGIT-1:0] a_sl, b_sl, s_sl;
  logic             c_out, c_msb;
  logic [WIDTH-1:0] acc_shift;
  logic             last_slice;

  always_comb begin
    a_sl = a_q[DIGIT-1:0];
    b_sl = b_q[DIGIT-1:0];
    {c_out, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry_q};
    // Sum bit = a ^ b ^ carry-in, so the carry into the slice MSB is
    // recovered without a second adder.
    c_msb = s_sl[DIGIT-1] ^ a_sl[DIGIT-1] ^ b_sl[DIGIT-1];
    // New slice enters at the top; after N shifts the LSB slice sits at bit 0.
    acc_shift = (acc_q >> DIGIT) | (WIDTH'(s_sl) << (WIDTH - DIGIT));
    last_slice = (idx_q == CW'(N - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    co_d    = co_q;
    ov_d    = ov_q;
    zero_d  = zero_q;
    idx_d   = idx_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          // Subtract as a + ~b + 1: invert b here, inject the +1 as carry-in.
          b_d     = sub ? ~b : b;
          carry_d = sub;
          acc_d   = '0;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = c_out;
        acc_d   = acc_shift;
        idx_d   = idx_q + CW'(1);
        if (last_slice) begin
          state_d = IDLE;
          done_d  = 1'b1;
          sum_d   = acc_shift;
          co_d    = c_out;
          ov_d    = c_msb ^ c_out;
          zero_d  = (acc_shift == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      zero_q  <= 1'b1;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      zero_q  <= zero_d;
      idx_q   <= idx_d;
    end
  end

  assign busy     = (state_q == BUSY);
  assign done     = done_q;
  assign sum      = sum_q;
  assign carryout = co_q;
  assign overflow = ov_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub: directed vectors on an 8-bit/2-bit instance
// plus exhaustive 4-bit checks on DIGIT=1 and DIGIT=4 instances.
// Expected results are queued at the accepting edge; a monitor pops and
// compares whenever a done pulse appears, including the done cycle number.
module tb_serial_addsub;

  typedef struct {
    logic [7:0] sum;
    logic       co;
    logic       ov;
    logic       z;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ov;
    logic       z;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   nvec = 0;
  int   nmis = 0;

  exp_t sb_m[$];
  exp_t sb_p[$];
  exp_t sb_q[$];
  vec_t vt[10];

  // main instance: WIDTH=8, DIGIT=2
  logic       m_start, m_sub, m_busy, m_done, m_co, m_ov, m_z;
  logic [7:0] m_a, m_b, m_sum;
  // WIDTH=4, DIGIT=1
  logic       p_start, p_sub, p_busy, p_done, p_co, p_ov, p_z;
  logic [3:0] p_a, p_b, p_sum;
  // WIDTH=4, DIGIT=4
  logic       q_start, q_sub, q_busy, q_done, q_co, q_ov, q_z;
  logic [3:0] q_a, q_b, q_sum;

  serial_addsub #(.WIDTH(8), .DIGIT(2)) u_m (
    .clk(clk), .reset(reset), .start(m_start), .sub(m_sub), .a(m_a), .b(m_b),
    .busy(m_busy), .done(m_done), .sum(m_sum), .carryout(m_co),
    .overflow(m_ov), .zero(m_z)
  );
  serial_addsub #(.WIDTH(4), .DIGIT(1)) u_p (
    .clk(clk), .reset(reset), .start(p_start), .sub(p_sub), .a(p_a), .b(p_b),
    .busy(p_busy), .done(p_done), .sum(p_sum), .carryout(p_co),
    .overflow(p_ov), .zero(p_z)
  );
  serial_addsub #(.WIDTH(4), .DIGIT(4)) u_q (
    .clk(clk), .reset(reset), .start(q_start), .sub(q_sub), .a(q_a), .b(q_b),
    .busy(q_busy), .done(q_done), .sum(q_sum), .carryout(q_co),
    .overflow(q_ov), .zero(q_z)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural reference for the exhaustive runs: integer add for sum and
  // carry, true signed range test for overflow.
  function automatic exp_t model(input int w, input int av, input int bv,
                                 input int sb, input int c);
    exp_t e;
    int mask, bb, full, sa, sbv, r;
    mask  = (1 << w) - 1;
    bb    = (sb != 0) ? (~bv & mask) : bv;
    full  = av + bb + sb;
    sa    = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sbv   = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
    r     = (sb != 0) ? sa - sbv : sa + sbv;
    e.sum = 8'(full & mask);
    e.co  = ((full >> w) & 1) != 0;
    e.ov  = (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
    e.z   = (full & mask) == 0;
    e.cyc = c;
    return e;
  endfunction

  task automatic chk(input string nm, input exp_t e, input logic [7:0] s,
                     input logic co, input logic ov, input logic z);
    nvec++;
    if (s !== e.sum || co !== e.co || ov !== e.ov || z !== e.z || cyc != e.cyc) begin
      nmis++;
      $display("FAIL %s: got sum=%h co=%b ov=%b z=%b cyc=%0d, want sum=%h co=%b ov=%b z=%b cyc=%0d",
               nm, s, co, ov, z, cyc, e.sum, e.co, e.ov, e.z, e.cyc);
    end else begin
      $display("ok   %s: sum=%h co=%b ov=%b z=%b cyc=%0d", nm, s, co, ov, z, cyc);
    end
  endtask

  task automatic chk_rst(input string nm);
    nvec++;
    if (m_busy !== 1'b0 || m_done !== 1'b0 || m_sum !== 8'h00 || m_co !== 1'b0 ||
        m_ov !== 1'b0 || m_z !== 1'b1) begin
      nmis++;
      $display("FAIL %s: got busy=%b done=%b sum=%h co=%b ov=%b z=%b, want 0 0 00 0 0 1",
               nm, m_busy, m_done, m_sum, m_co, m_ov, m_z);
    end else begin
      $display("ok   %s: outputs at reset values", nm);
    end
  endtask

  task automatic unexpected(input string nm);
    nvec++;
    nmis++;
    $display("FAIL %s: got done pulse at cyc=%0d, want no done (nothing pending)", nm, cyc);
  endtask

  // Monitor: compares on every done pulse, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_done === 1'b1) begin
        if (sb_m.size() == 0) unexpected("main_done");
        else chk("main", sb_m.pop_front(), m_sum, m_co, m_ov, m_z);
      end
      if (p_done === 1'b1) begin
        if (sb_p.size() == 0) unexpected("w4d1_done");
        else chk("w4d1", sb_p.pop_front(), {4'h0, p_sum}, p_co, p_ov, p_z);
      end
      if (q_done === 1'b1) begin
        if (sb_q.size() == 0) unexpected("w4d4_done");
        else chk("w4d4", sb_q.pop_front(), {4'h0, q_sum}, q_co, q_ov, q_z);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout at cyc=%0d, want completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    //       a      b      sub   sum    co    ov    z
    vt = '{
      '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0},
      '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0},
      '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1},
      '{8'h02, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0},
      '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0},
      '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1},
      '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1},
      '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0},
      '{8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1, 1'b0},
      '{8'h9C, 8'h64, 1'b1, 8'h38, 1'b1, 1'b1, 1'b0}
    };
    m_start = 0; m_sub = 0; m_a = 0; m_b = 0;
    p_start = 0; p_sub = 0; p_a = 0; p_b = 0;
    q_start = 0; q_sub = 0; q_a = 0; q_b = 0;
    reset = 1'b1;
    #1;
    chk_rst("reset_state");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors; each next start lands in the previous done cycle.
    for (int i = 0; i < 10; i++) begin
      m_a = vt[i].a; m_b = vt[i].b; m_sub = vt[i].sub; m_start = 1'b1;
      @(posedge clk);
      #1;
      sb_m.push_back('{vt[i].s, vt[i].co, vt[i].ov, vt[i].z, cyc + 4});
      nvec++;
      if (m_busy !== 1'b1) begin
        nmis++;
        $display("FAIL busy_after_start: got busy=%b, want 1", m_busy);
      end
      @(negedge clk);
      m_start = 1'b0;
      repeat (4) @(negedge clk);
    end

    // Starts during BUSY with other operands must be ignored.
    m_a = 8'h05; m_b = 8'h03; m_sub = 1'b0; m_start = 1'b1;
    @(posedge clk);
    #1;
    sb_m.push_back('{8'h08, 1'b0, 1'b0, 1'b0, cyc + 4});
    @(negedge clk);
    m_start = 1'b0;
    @(negedge clk);
    m_a = 8'h01; m_b = 8'h01; m_sub = 1'b1; m_start = 1'b1;
    @(negedge clk);
    m_a = 8'h40; m_b = 8'h40; m_sub = 1'b0; m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    @(negedge clk);

    // start held high: 10 - 3 = 7 every N+1 = 5 cycles.
    m_a = 8'h0A; m_b = 8'h03; m_sub = 1'b1; m_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      repeat ((k == 0) ? 1 : 5) @(posedge clk);
      #1;
      sb_m.push_back('{8'h07, 1'b1, 1'b0, 1'b0, cyc + 4});
    end
    @(negedge clk);
    m_start = 1'b0;
    repeat (4) @(negedge clk);

    // Reset between edges during cycle 2 of BUSY abandons the operation.
    m_a = 8'h05; m_b = 8'h03; m_sub = 1'b0; m_start = 1'b1;
    @(posedge clk);
    #1;
    sb_m.push_back('{8'h08, 1'b0, 1'b0, 1'b0, cyc + 4});
    @(negedge clk);
    m_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_rst("reset_mid_busy");
    void'(sb_m.pop_back());
    @(negedge clk);
    reset = 1'b0;
    m_a = 8'h02; m_b = 8'h01; m_sub = 1'b1; m_start = 1'b1;
    @(posedge clk);
    #1;
    sb_m.push_back('{8'h01, 1'b1, 1'b0, 1'b0, cyc + 4});
    @(negedge clk);
    m_start = 1'b0;
    repeat (4) @(negedge clk);

    // Exhaustive 4-bit runs on both narrow instances in parallel.
    fork
      begin
        for (int s = 0; s < 2; s++)
          for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) begin
              p_a = 4'(x); p_b = 4'(y); p_sub = s[0]; p_start = 1'b1;
              @(posedge clk);
              #1;
              sb_p.push_back(model(4, x, y, s, cyc + 4));
              @(negedge clk);
              p_start = 1'b0;
              repeat (4) @(negedge clk);
            end
      end
      begin
        for (int s = 0; s < 2; s++)
          for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) begin
              q_a = 4'(x); q_b = 4'(y); q_sub = s[0]; q_start = 1'b1;
              @(posedge clk);
              #1;
              sb_q.push_back(model(4, x, y, s, cyc + 1));
              @(negedge clk);
              q_start = 1'b0;
              repeat (1) @(negedge clk);
            end
      end
    join

    repeat (8) @(negedge clk);
    #1;
    nvec++;
    if (sb_m.size() != 0 || sb_p.size() != 0 || sb_q.size() != 0) begin
      nmis++;
      $display("FAIL pending_results: got %0d/%0d/%0d outstanding, want 0/0/0",
               sb_m.size(), sb_p.size(), sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
